// File: rtl/toy_mext_iq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | toy_pack : shared types and sizing constants for the M-ext IQ      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package toy_pack;
  localparam int REG_WIDTH        = 32;
  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int INST_ID_WIDTH    = 8;
  localparam int MEXT_IQ_DEPTH    = 4;
  localparam int MEXT_IQ_WB_NUM   = 2;

  typedef struct packed {
    logic [INST_ID_WIDTH-1:0]    inst_id;
    logic [31:0]                 inst_pld;
    logic [PHY_REG_ID_WIDTH-1:0] inst_rd;
    logic [REG_WIDTH-1:0]        reg_rs1_val;
    logic [REG_WIDTH-1:0]        reg_rs2_val;
  } forward_pkg;

  typedef struct packed {
    forward_pkg                  fwd;
    logic [PHY_REG_ID_WIDTH-1:0] rs1_idx;
    logic [PHY_REG_ID_WIDTH-1:0] rs2_idx;
    logic                        rs1_rdy;
    logic                        rs2_rdy;
  } mext_iq_entry_t;
endpackage
`default_nettype wire

// File: rtl/toy_mext_iq_wb_match.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | toy_mext_iq_wb_match : one operand index vs. all writeback ports,  |
// | lowest matching port wins. Rev 1.0                                 |
// +--------------------------------------------------------------------+
module toy_mext_iq_wb_match
  import toy_pack::*;
#(
  parameter int WB_NUM = MEXT_IQ_WB_NUM
) (
  input  logic [PHY_REG_ID_WIDTH-1:0]             idx,
  input  logic [WB_NUM-1:0]                       wb_en,
  input  logic [WB_NUM-1:0][PHY_REG_ID_WIDTH-1:0] wb_index,
  input  logic [WB_NUM-1:0][REG_WIDTH-1:0]        wb_val,
  output logic                                    hit,
  output logic [REG_WIDTH-1:0]                    val
);
  // Scan high to low so the lowest matching port is the last to write.
  always_comb begin
    hit = 1'b0;
    val = '0;
    for (int p = WB_NUM - 1; p >= 0; p--) begin
      if (wb_en[p] && (wb_index[p] == idx)) begin
        hit = 1'b1;
        val = wb_val[p];
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/toy_mext_iq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | toy_mext_iq : collapsing issue queue for the M-extension unit.     |
// | Optional same-cycle bypass: TOY_MEXT_IQ_BYPASS_EN. Rev 1.0         |
// +--------------------------------------------------------------------+
module toy_mext_iq
  import toy_pack::*;
#(
  parameter int DEPTH  = MEXT_IQ_DEPTH,
  parameter int WB_NUM = MEXT_IQ_WB_NUM
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enq_vld,
  output logic                                    enq_rdy,
  input  forward_pkg                              enq_pld,
  input  logic [PHY_REG_ID_WIDTH-1:0]             enq_rs1_idx,
  input  logic [PHY_REG_ID_WIDTH-1:0]             enq_rs2_idx,
  input  logic                                    enq_rs1_rdy,
  input  logic                                    enq_rs2_rdy,
  input  logic [WB_NUM-1:0]                       wb_en,
  input  logic [WB_NUM-1:0][PHY_REG_ID_WIDTH-1:0] wb_index,
  input  logic [WB_NUM-1:0][REG_WIDTH-1:0]        wb_val,
  input  logic                                    cancel_en,
  output logic                                    instruction_vld,
  input  logic                                    instruction_rdy,
  output forward_pkg                              instruction_pld,
  output logic [$clog2(DEPTH+1)-1:0]              iq_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  mext_iq_entry_t r_ent [DEPTH];
  logic [CW-1:0]  r_count;

  // Slots 0..DEPTH-1 are the queue after capture; slot DEPTH is the incoming op.
  mext_iq_entry_t w_cap [DEPTH+1];
  mext_iq_entry_t w_nxt [DEPTH];
  logic [DEPTH-1:0] w_slot_rdy;
  logic [IW-1:0]  w_sel;
  logic           w_any;
  logic           w_byp;
  logic           w_issue_fire;
  logic           w_q_issue;
  logic           w_enq_wr;
  logic [CW-1:0]  w_wr_ptr;

  for (genvar i = 0; i <= DEPTH; i++) begin : g_cap
    mext_iq_entry_t        w_src;
    mext_iq_entry_t        w_out;
    logic                  w_hit1, w_hit2;
    logic [REG_WIDTH-1:0]  w_val1, w_val2;

    if (i < DEPTH) begin : g_slot
      assign w_src = r_ent[i];
      assign w_slot_rdy[i] = (CW'(i) < r_count) & r_ent[i].rs1_rdy & r_ent[i].rs2_rdy;
    end else begin : g_enq
      assign w_src = '{fwd: enq_pld, rs1_idx: enq_rs1_idx, rs2_idx: enq_rs2_idx,
                       rs1_rdy: enq_rs1_rdy, rs2_rdy: enq_rs2_rdy};
    end

    toy_mext_iq_wb_match #(.WB_NUM(WB_NUM)) u_m1 (
      .idx(w_src.rs1_idx), .wb_en(wb_en), .wb_index(wb_index), .wb_val(wb_val),
      .hit(w_hit1), .val(w_val1)
    );
    toy_mext_iq_wb_match #(.WB_NUM(WB_NUM)) u_m2 (
      .idx(w_src.rs2_idx), .wb_en(wb_en), .wb_index(wb_index), .wb_val(wb_val),
      .hit(w_hit2), .val(w_val2)
    );

    always_comb begin
      w_out = w_src;
      if (!w_src.rs1_rdy && w_hit1) begin
        w_out.rs1_rdy         = 1'b1;
        w_out.fwd.reg_rs1_val = w_val1;
      end
      if (!w_src.rs2_rdy && w_hit2) begin
        w_out.rs2_rdy         = 1'b1;
        w_out.fwd.reg_rs2_val = w_val2;
      end
    end
    assign w_cap[i] = w_out;
  end

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_slot_rdy[i]) begin
        w_any = 1'b1;
        w_sel = IW'(i);
      end
    end
  end

  assign enq_rdy  = (r_count < CW'(DEPTH));
  assign iq_count = r_count;

`ifdef TOY_MEXT_IQ_BYPASS_EN
  assign w_byp = ~w_any & enq_vld & enq_rdy & w_cap[DEPTH].rs1_rdy & w_cap[DEPTH].rs2_rdy;
  assign instruction_pld = w_any ? r_ent[w_sel].fwd : w_cap[DEPTH].fwd;
`else
  assign w_byp = 1'b0;
  assign instruction_pld = r_ent[w_sel].fwd;
`endif

  assign instruction_vld = (w_any | w_byp) & ~cancel_en;
  assign w_issue_fire    = instruction_vld & instruction_rdy;
  assign w_q_issue       = w_issue_fire & w_any;
  // A bypassed op leaves through the issue port and is never stored.
  assign w_enq_wr        = enq_vld & enq_rdy & ~cancel_en & ~(w_issue_fire & ~w_any);
  assign w_wr_ptr        = r_count - CW'(w_q_issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = w_cap[i];
      if (w_q_issue && (IW'(i) >= w_sel)) w_nxt[i] = w_cap[i+1];
      if (w_enq_wr && (CW'(i) == w_wr_ptr)) w_nxt[i] = w_cap[DEPTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt[i];
      if (cancel_en) r_count <= '0;
      else           r_count <= r_count + CW'(w_enq_wr) - CW'(w_q_issue);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_toy_mext_iq.sv
`default_nettype none
// Directed self-checking bench for toy_mext_iq (default DEPTH=4, WB_NUM=2).
module tb_toy_mext_iq;
  import toy_pack::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enq_vld = 1'b0;
  logic enq_rdy;
  forward_pkg enq_pld = '0;
  logic [PHY_REG_ID_WIDTH-1:0] enq_rs1_idx = '0, enq_rs2_idx = '0;
  logic enq_rs1_rdy = 1'b0, enq_rs2_rdy = 1'b0;
  logic [1:0] wb_en = '0;
  logic [1:0][PHY_REG_ID_WIDTH-1:0] wb_index = '0;
  logic [1:0][REG_WIDTH-1:0] wb_val = '0;
  logic cancel_en = 1'b0;
  logic instruction_vld;
  logic instruction_rdy = 1'b0;
  forward_pkg instruction_pld;
  logic [2:0] iq_count;

  int errors = 0;
  int checks = 0;

  toy_mext_iq dut (
    .clk(clk), .rst(rst),
    .enq_vld(enq_vld), .enq_rdy(enq_rdy), .enq_pld(enq_pld),
    .enq_rs1_idx(enq_rs1_idx), .enq_rs2_idx(enq_rs2_idx),
    .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
    .wb_en(wb_en), .wb_index(wb_index), .wb_val(wb_val),
    .cancel_en(cancel_en),
    .instruction_vld(instruction_vld), .instruction_rdy(instruction_rdy),
    .instruction_pld(instruction_pld), .iq_count(iq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [7:0] id,
                     input logic r1, input logic [5:0] i1, input logic [31:0] v1,
                     input logic r2, input logic [5:0] i2, input logic [31:0] v2);
    forward_pkg f;
    f = '0;
    f.inst_id     = id;
    f.inst_pld    = 32'h0200_0033;
    f.inst_rd     = id[5:0];
    f.reg_rs1_val = r1 ? v1 : 32'h0;
    f.reg_rs2_val = r2 ? v2 : 32'h0;
    enq_vld     = 1'b1;
    enq_pld     = f;
    enq_rs1_rdy = r1;
    enq_rs1_idx = i1;
    enq_rs2_rdy = r2;
    enq_rs2_idx = i2;
  endtask

  task automatic enq_ready(input logic [7:0] id);
    enq(id, 1'b1, 6'd1, {24'h0, id}, 1'b1, 6'd2, {16'h0, id, 8'h00});
  endtask

  task automatic noenq();
    enq_vld = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_vld", 64'(instruction_vld), 64'd0);
    chk("rst_enq_rdy", 64'(enq_rdy), 64'd1);
    chk("rst_count", 64'(iq_count), 64'd0);
    chk("rst_pld_id", 64'(instruction_pld.inst_id), 64'd0);
    rst = 1'b0;
    cyc();

    // In-order issue of three ready ops
    instruction_rdy = 1'b1;
    enq_ready(8'd1); #1;
    chk("t1_empty_vld", 64'(instruction_vld), 64'd0);
    cyc();
    chk("t1_cnt_a", 64'(iq_count), 64'd1);
    enq_ready(8'd2); #1;
    chk("t1_vld1", 64'(instruction_vld), 64'd1);
    chk("t1_id1", 64'(instruction_pld.inst_id), 64'd1);
    chk("t1_id1_rs2", 64'(instruction_pld.reg_rs2_val), 64'h100);
    cyc();
    chk("t1_cnt_b", 64'(iq_count), 64'd1);
    enq_ready(8'd3); #1;
    chk("t1_id2", 64'(instruction_pld.inst_id), 64'd2);
    cyc();
    chk("t1_cnt_c", 64'(iq_count), 64'd1);
    noenq(); #1;
    chk("t1_id3", 64'(instruction_pld.inst_id), 64'd3);
    cyc();
    chk("t1_cnt_d", 64'(iq_count), 64'd0);
    chk("t1_vld_end", 64'(instruction_vld), 64'd0);

    // Younger ready op overtakes a waiting one; writeback on port 1 wakes it
    instruction_rdy = 1'b0;
    enq(8'd5, 1'b0, 6'd12, 32'h0, 1'b1, 6'd3, 32'h22); #1;
    cyc();
    enq_ready(8'd6); #1;
    chk("t2_wait_vld", 64'(instruction_vld), 64'd0);
    cyc();
    noenq();
    instruction_rdy = 1'b1; #1;
    chk("t2_vld6", 64'(instruction_vld), 64'd1);
    chk("t2_id6", 64'(instruction_pld.inst_id), 64'd6);
    cyc();
    chk("t2_cnt1", 64'(iq_count), 64'd1);
    wb_en = 2'b10; wb_index[1] = 6'd12; wb_val[1] = 32'hDEAD; #1;
    chk("t2_wb_cycle_vld", 64'(instruction_vld), 64'd0);
    cyc();
    wb_en = 2'b00; #1;
    chk("t2_vld5", 64'(instruction_vld), 64'd1);
    chk("t2_id5", 64'(instruction_pld.inst_id), 64'd5);
    chk("t2_rs1", 64'(instruction_pld.reg_rs1_val), 64'hDEAD);
    chk("t2_rs2", 64'(instruction_pld.reg_rs2_val), 64'h22);
    cyc();
    chk("t2_cnt0", 64'(iq_count), 64'd0);

    // Enqueue-time capture, both ports match: port 0 wins
    enq(8'd7, 1'b1, 6'd4, 32'h11, 1'b0, 6'd7, 32'h0);
    wb_en = 2'b11; wb_index[0] = 6'd7; wb_val[0] = 32'h77;
    wb_index[1] = 6'd7; wb_val[1] = 32'h99; #1;
    chk("t3_same_vld", 64'(instruction_vld), 64'd0);
    cyc();
    noenq(); wb_en = 2'b00; #1;
    chk("t3_vld", 64'(instruction_vld), 64'd1);
    chk("t3_id", 64'(instruction_pld.inst_id), 64'd7);
    chk("t3_rs2", 64'(instruction_pld.reg_rs2_val), 64'h77);
    chk("t3_rs1", 64'(instruction_pld.reg_rs1_val), 64'h11);
    cyc();
    chk("t3_cnt0", 64'(iq_count), 64'd0);

    // Fill, hold under back-pressure, no full-with-pop bypass, drain
    instruction_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      enq_ready(8'(10 + k));
      cyc();
    end
    noenq(); #1;
    chk("t4_full_cnt", 64'(iq_count), 64'd4);
    chk("t4_full_rdy", 64'(enq_rdy), 64'd0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t4_hold_id", 64'(instruction_pld.inst_id), 64'd10);
      chk("t4_hold_vld", 64'(instruction_vld), 64'd1);
    end
    instruction_rdy = 1'b1;
    enq_ready(8'd14); #1;
    chk("t4_pop_rdy", 64'(enq_rdy), 64'd0);
    chk("t4_fire10", 64'(instruction_pld.inst_id), 64'd10);
    cyc();
    noenq(); #1;
    chk("t4_cnt3", 64'(iq_count), 64'd3);
    chk("t4_fire11", 64'(instruction_pld.inst_id), 64'd11);
    cyc();
    chk("t4_fire12", 64'(instruction_pld.inst_id), 64'd12);
    cyc();
    chk("t4_fire13", 64'(instruction_pld.inst_id), 64'd13);
    cyc();
    chk("t4_cnt0", 64'(iq_count), 64'd0);
    chk("t4_vld0", 64'(instruction_vld), 64'd0);

    // Cancel with three entries and a concurrent enqueue
    instruction_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enq_ready(8'(20 + k));
      cyc();
    end
    enq_ready(8'd23);
    instruction_rdy = 1'b1;
    cancel_en = 1'b1; #1;
    chk("t5_cancel_vld", 64'(instruction_vld), 64'd0);
    chk("t5_cnt3", 64'(iq_count), 64'd3);
    cyc();
    cancel_en = 1'b0; noenq(); #1;
    chk("t5_cnt0", 64'(iq_count), 64'd0);
    chk("t5_vld0", 64'(instruction_vld), 64'd0);
    chk("t5_enq_rdy", 64'(enq_rdy), 64'd1);

    // Asynchronous reset mid-operation
    instruction_rdy = 1'b0;
    enq_ready(8'd30);
    cyc();
    noenq(); #1;
    chk("t6_cnt1", 64'(iq_count), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_cnt", 64'(iq_count), 64'd0);
    chk("t6_async_vld", 64'(instruction_vld), 64'd0);
    rst = 1'b0;
    cyc();

`ifdef TOY_MEXT_IQ_BYPASS_EN
    // Same-cycle bypass into an empty queue
    instruction_rdy = 1'b1;
    enq_ready(8'd40); #1;
    chk("t7_byp_vld", 64'(instruction_vld), 64'd1);
    chk("t7_byp_id", 64'(instruction_pld.inst_id), 64'd40);
    cyc();
    noenq(); #1;
    chk("t7_byp_cnt", 64'(iq_count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/toy_mext_iq.md
# toy_mext_iq

Issue queue feeding the M-extension execution unit (`toy_mext`). Holds up to `DEPTH` multiply/divide micro-ops from rename/dispatch and captures operand values from writeback broadcasts. Issues the oldest fully-ready entry as a `forward_pkg` over the `instruction_vld`/`instruction_rdy` handshake. Acts as the initiator side of the mext issue interface and honours its divider back-pressure and `cancel_en` flush.

## Interface

Reset is asynchronous and active-high; a single clock `clk` drives the block.

Parameters:
- `DEPTH`, 4: number of queue entries; legal range 2..16.
- `WB_NUM`, 2: number of writeback capture ports.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous active-high reset.
- `enq_vld`, input, 1: dispatch offers a micro-op.
- `enq_rdy`, output, 1: queue accepts; equals `count < DEPTH`.
- `enq_pld`, input, `forward_pkg`: micro-op; `reg_rs1_val`/`reg_rs2_val` are valid only where the matching ready flag is set.
- `enq_rs1_idx`, `enq_rs2_idx`, input, `PHY_REG_ID_WIDTH` each: source physical registers.
- `enq_rs1_rdy`, `enq_rs2_rdy`, input, 1 each: the corresponding source value is already present in `enq_pld`.
- `wb_en`, input, `WB_NUM`: writeback broadcast valid, one bit per port.
- `wb_index`, input, `WB_NUM` × `PHY_REG_ID_WIDTH`: writeback destination register.
- `wb_val`, input, `WB_NUM` × `REG_WIDTH`: writeback data.
- `cancel_en`, input, 1: pipeline flush.
- `instruction_vld`, output, 1: issue valid.
- `instruction_rdy`, input, 1: mext accepts.
- `instruction_pld`, output, `forward_pkg`: issued micro-op with both operand values filled in.
- `iq_count`, output, `$clog2(DEPTH+1)`: current occupancy.

## Operation

- The queue is collapsing: slot 0 holds the oldest entry, and valid entries always occupy slots `0..count-1`.
- Each entry holds: `forward_pkg`, `rs1_idx`, `rs2_idx`, `rs1_rdy`, `rs2_rdy`.
- Capture: for every valid entry with `rsX_rdy == 0`, if any `wb_en[p]` is set and `wb_index[p] == rsX_idx`, then latch `wb_val[p]` into `reg_rsX_val` and set `rsX_rdy`.
  - If several ports match the same operand, the lowest port wins.
  - An entry may have both rs1 and rs2 captured in the same cycle.
- Enqueue-time capture: an operand that is not ready on enqueue is also checked against the `wb_*` ports in the same cycle. A match sets it ready on write, so no broadcast is lost.
- Select: `sel` = the lowest slot with both ready flags set.
  - `instruction_vld = any_ready & ~cancel_en`.
  - `instruction_pld` = the payload in slot `sel`.
- Fire (`instruction_vld & instruction_rdy`): slot `sel` is removed and slots above it shift down by one.
- Enqueue fire (`enq_vld & enq_rdy & ~cancel_en`): the new entry is written to slot `count`, or to slot `count-1` if an issue fire happens in the same cycle.
- Count update: `count_next = count + enq_fire - issue_fire`.
- `cancel_en`: at the next edge every valid bit and `count` are cleared. In the cancel cycle no issue occurs and any enqueue is dropped.
- The `inst_pld` funct3 field is not interpreted; mul and div entries are handled identically.

## Timing

- Reset values: `instruction_vld=0`, `enq_rdy=1`, `iq_count=0`, all entries invalid, payload registers 0.
- Enqueue of a fully ready op at edge T: issuable in cycle T+1 (`instruction_vld` is high during T+1).
- A writeback at cycle T that completes an entry makes `instruction_vld` assertable in cycle T+1.
- `instruction_vld` and `instruction_pld` are combinational from registered state plus `cancel_en`.
  - They may drop without a fire, on cancel.
  - Otherwise the same entry is held stable while `instruction_rdy` is low, unless an older entry becomes ready.
- Full: `enq_rdy=0` even when an issue fires in the same cycle. There is no full-with-pop bypass.
- Empty: `instruction_vld=0`.
- Reset mid-operation: all state clears immediately (asynchronous).

## Configuration

- `TOY_MEXT_IQ_BYPASS_EN` defined: when the queue has no ready entry and a fully ready enqueue arrives (both flags set, or completed by same-cycle capture), the enqueue is presented directly on `instruction_pld` in the same cycle.
  - If the bypass fires (`instruction_rdy=1`), the entry is not written and `count` is unchanged.
  - Otherwise it is written normally.
  - Bypass is suppressed under `cancel_en`.
- Undefined: minimum enqueue-to-issue latency is 1 cycle, as described above.

## Structure

- `toy_pack` gains the following; the entry typedef and constants live in the shared package.
  - `mext_iq_entry_t` (`forward_pkg` plus index and ready fields).
  - `MEXT_IQ_DEPTH = 4`.
  - `MEXT_IQ_WB_NUM = 2`.
- One sub-module, `toy_mext_iq_wb_match`: compares one operand index against all `WB_NUM` ports and returns hit plus value. It is instantiated 2 × (`DEPTH` + 1) times.

## Test plan

- Enqueue 3 ready ops (ids 1, 2, 3) with `instruction_rdy=1` → issued in order 1, 2, 3 on consecutive cycles, starting 1 cycle after the first enqueue; `iq_count` goes 1, 1, 1, 0.
- Enqueue id 5 (rs1 waiting on p12), then ready id 6 → id 6 issues first. A `wb_en[1]` with `wb_index=12` and `wb_val=0xDEAD` then makes id 5 issue the next cycle with `reg_rs1_val=0xDEAD`.
- Enqueue with `rs2_idx=7` not ready while `wb_en[0]` and `wb_index[0]=7` in the same cycle → the entry is issuable the next cycle with the captured value.
- Fill to `DEPTH` with `instruction_rdy=0` → `enq_rdy=0` and `iq_count=4`. Hold `instruction_rdy` low for 10 cycles → the payload stays stable. Then raise it → 4 fires.
- Queue holding 3 entries, `cancel_en` pulsed with `enq_vld=1` → `instruction_vld=0` in that cycle, `iq_count=0` next cycle, and the new op is dropped.
- With `TOY_MEXT_IQ_BYPASS_EN`: empty queue, ready enqueue, `instruction_rdy=1` → issue in the same cycle and `iq_count` stays 0.
